// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment scanner: prescaled digit rotation with dead-time,
// per-digit blank/dp, and a double-buffered value that only changes at frame wrap.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 50000,
  parameter int DEADTIME   = 500,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0]    LAST_P = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    DEAD_P = PW'(DEADTIME);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VW-1:0]         stage_val_q, stage_val_d;
  logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d;
  logic [NUM_DIGITS-1:0] stage_blank_q, stage_blank_d;
  logic                  pending_q, pending_d;
  logic [VW-1:0]         shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  frame_done_q, frame_done_d;

  logic                  wrap_s;
  logic [3:0]            nib_s;
  logic                  blank_cur_s;
  logic [NUM_DIGITS-1:0] onehot_s;

  // Scan position, double-buffer load path and pin values for the next cycle.
  always_comb begin
    wrap_s         = en && (pcnt_q == LAST_P) && (idx_q == LAST_I);
    pcnt_d         = pcnt_q;
    idx_d          = idx_q;
    stage_val_d    = stage_val_q;
    stage_dp_d     = stage_dp_q;
    stage_blank_d  = stage_blank_q;
    pending_d      = pending_q;
    shadow_val_d   = shadow_val_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;

    if (en) begin
      if (pcnt_q == LAST_P) begin
        pcnt_d = {PW{1'b0}};
        if (idx_q == LAST_I) begin
          idx_d = {IDX_W{1'b0}};
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end else begin
      pcnt_d = pcnt_q;
    end

    // A load at the wrap or while dark can go straight to the shadow without tearing.
    if (load && (wrap_s || !en)) begin
      stage_val_d    = value;
      stage_dp_d     = dp;
      stage_blank_d  = blank;
      shadow_val_d   = value;
      shadow_dp_d    = dp;
      shadow_blank_d = blank;
      pending_d      = 1'b0;
    end else if (load) begin
      stage_val_d   = value;
      stage_dp_d    = dp;
      stage_blank_d = blank;
      pending_d     = 1'b1;
    end else if (wrap_s && pending_q) begin
      shadow_val_d   = stage_val_q;
      shadow_dp_d    = stage_dp_q;
      shadow_blank_d = stage_blank_q;
      pending_d      = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    nib_s       = shadow_val_q[{idx_q, 2'b00} +: 4];
    blank_cur_s = shadow_blank_q[idx_q];
    onehot_s    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;

    if (en && (pcnt_q >= DEAD_P) && !blank_cur_s) begin
      anode_d = onehot_s;
    end else begin
      anode_d = {NUM_DIGITS{1'b0}};
    end

    if (blank_cur_s) begin
      seg_d    = 7'h00;
      seg_dp_d = 1'b0;
    end else begin
      seg_d    = seg7_decode(nib_s);
      seg_dp_d = shadow_dp_q[idx_q];
    end

    digit_idx_d  = idx_q;
    frame_done_d = wrap_s;
  end

  // State and output registers; outputs are held active-high internally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q         <= {PW{1'b0}};
      idx_q          <= {IDX_W{1'b0}};
      stage_val_q    <= {VW{1'b0}};
      stage_dp_q     <= {NUM_DIGITS{1'b0}};
      stage_blank_q  <= {NUM_DIGITS{1'b0}};
      pending_q      <= 1'b0;
      shadow_val_q   <= {VW{1'b0}};
      shadow_dp_q    <= {NUM_DIGITS{1'b0}};
      shadow_blank_q <= {NUM_DIGITS{1'b0}};
      anode_q        <= {NUM_DIGITS{1'b0}};
      seg_q          <= 7'h00;
      seg_dp_q       <= 1'b0;
      digit_idx_q    <= {IDX_W{1'b0}};
      frame_done_q   <= 1'b0;
    end else begin
      pcnt_q         <= pcnt_d;
      idx_q          <= idx_d;
      stage_val_q    <= stage_val_d;
      stage_dp_q     <= stage_dp_d;
      stage_blank_q  <= stage_blank_d;
      pending_q      <= pending_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      anode_q        <= anode_d;
      seg_q          <= seg_d;
      seg_dp_q       <= seg_dp_d;
      digit_idx_q    <= digit_idx_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign anode      = ACTIVE_LOW ? ~anode_q  : anode_q;
  assign seg        = ACTIVE_LOW ? ~seg_q    : seg_q;
  assign seg_dp     = ACTIVE_LOW ? ~seg_dp_q : seg_dp_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed scenarios plus random traffic for seg7_scan_mux (4 digits, prescale 4,
// dead-time 1, active-low pins) against a frame-position reference model.
module tb_seg7_scan_mux;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int DT = 1;
  localparam int FRAME = N * P;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seg7_scan_mux #(.NUM_DIGITS(N), .PRESCALE(P), .DEADTIME(DT), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .value(value), .dp(dp), .blank(blank),
    .anode(anode), .seg(seg), .seg_dp(seg_dp), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int fd_count = 0;

  // reference model: position within the frame plus the two value buffers
  int          m_pos;
  logic [15:0] m_sh_val, m_st_val;
  logic [3:0]  m_sh_dp, m_st_dp, m_sh_bl, m_st_bl;
  bit          m_pend;
  logic [3:0]  exp_anode;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [1:0]  exp_idx;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_sh_val = 16'h0; m_st_val = 16'h0;
    m_sh_dp = 4'h0; m_st_dp = 4'h0; m_sh_bl = 4'h0; m_st_bl = 4'h0;
    m_pend = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic l, input logic [15:0] v,
                            input logic [3:0] d, input logic [3:0] b);
    int di, pc;
    logic [3:0] nib;
    di  = m_pos / P;
    pc  = m_pos % P;
    nib = 4'((m_sh_val >> (4 * di)) & 16'h000F);
    exp_anode = (e && pc >= DT && !m_sh_bl[di]) ? ~(4'b0001 << di) : 4'b1111;
    exp_seg   = m_sh_bl[di] ? 7'h7F : ~HEX[nib];
    exp_dp    = m_sh_bl[di] ? 1'b1 : ~m_sh_dp[di];
    exp_idx   = 2'(di);
    exp_fd    = e && (m_pos == FRAME - 1);
    if (l && (exp_fd || !e)) begin
      m_st_val = v; m_st_dp = d; m_st_bl = b;
      m_sh_val = v; m_sh_dp = d; m_sh_bl = b;
      m_pend = 1'b0;
    end else if (l) begin
      m_st_val = v; m_st_dp = d; m_st_bl = b;
      m_pend = 1'b1;
    end else if (exp_fd && m_pend) begin
      m_sh_val = m_st_val; m_sh_dp = m_st_dp; m_sh_bl = m_st_bl;
      m_pend = 1'b0;
    end
    if (e) m_pos = (m_pos + 1) % FRAME;
  endtask

  task automatic tick(input string tag, input logic e, input logic l, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    en = e; load = l; value = v; dp = d; blank = b;
    model_step(e, l, v, d, b);
    @(posedge clk);
    #1;
    load = 1'b0;
    fd_count += int'(frame_done);
    chk({tag, ".anode"}, 16'(anode), 16'(exp_anode));
    chk({tag, ".seg"}, 16'(seg), 16'(exp_seg));
    chk({tag, ".dp"}, 16'(seg_dp), 16'(exp_dp));
    chk({tag, ".idx"}, 16'(digit_idx), 16'(exp_idx));
    chk({tag, ".fd"}, 16'(frame_done), 16'(exp_fd));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    #1;
    chk({tag, ".anode"}, 16'(anode), 16'h000F);
    chk({tag, ".seg"}, 16'(seg), 16'h007F);
    chk({tag, ".dp"}, 16'(seg_dp), 16'h0001);
    chk({tag, ".idx"}, 16'(digit_idx), 16'h0000);
    chk({tag, ".fd"}, 16'(frame_done), 16'h0000);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // run enabled with fixed data until the model reaches the given frame position
  task automatic run_to(input string tag, input int pos, input logic [15:0] v,
                        input logic [3:0] d, input logic [3:0] b);
    for (int k = 0; k < 2 * FRAME && m_pos != pos; k++) tick(tag, 1'b1, 1'b0, v, d, b);
    chk({tag, ".reach"}, 16'(m_pos), 16'(pos));
  endtask

  initial begin
    model_reset();
    // 1: reset mid-scan, then free-running rotation and frame_done rate
    do_reset("rst0");
    for (int k = 0; k < 6; k++) tick("s1a", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    do_reset("rst_mid");
    fd_count = 0;
    for (int k = 0; k < 2 * FRAME; k++) tick("s1", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    chk("s1.fd_count", 16'(fd_count), 16'd2);

    // 2: load while dark, then decode with dead-time
    do_reset("rst2");
    tick("s2.load", 1'b0, 1'b1, 16'h3A70, 4'b0100, 4'b0000);
    for (int k = 0; k < FRAME; k++) tick("s2", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // 3: tear-free load mid-frame
    tick("s3.pre", 1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
    run_to("s3.w", 0, 16'h0, 4'h0, 4'h0);
    run_to("s3.a", P, 16'h0, 4'h0, 4'h0);
    tick("s3.load", 1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0);
    for (int k = 0; k < 2 * FRAME; k++) tick("s3", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // 4: load coincident with the wrap
    run_to("s4.w", FRAME - 1, 16'h0, 4'h0, 4'h0);
    tick("s4.load", 1'b1, 1'b1, 16'h5555, 4'hF, 4'h0);
    for (int k = 0; k < 2 * FRAME; k++) tick("s4", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // 5: blanking, then freeze at idx 2 / pcnt 2
    tick("s5.load", 1'b1, 1'b1, 16'h9876, 4'b0011, 4'b1010);
    run_to("s5.w", 0, 16'h0, 4'h0, 4'h0);
    run_to("s5.f", 2 * P + 2, 16'h0, 4'h0, 4'h0);
    for (int k = 0; k < 10; k++) tick("s5.off", 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    chk("s5.frozen", 16'(m_pos), 16'(2 * P + 2));
    for (int k = 0; k < FRAME + 3; k++) tick("s5.on", 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      tick("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
           16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
